// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and counter sizing.
// Latency: not applicable (types and constant functions only).
// Backpressure: not applicable.
package serial_add_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Bits needed to count 0..value-1; at least one bit so WIDTH=2 still has a counter.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/full_add_bit.sv
// One-bit full adder assembled from two half adder cells and an OR of their carries.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluates continuously.
module full_add_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic ha0_s;
    logic ha0_c;
    logic ha1_c;

    // First half adder cell: operand bits.
    assign ha0_s = a ^ b;
    assign ha0_c = a & b;

    // Second half adder cell: partial sum with incoming carry.
    assign s     = ha0_s ^ cin;
    assign ha1_c = ha0_s & cin;

    // Only one of the two half-adder carries can be set, so OR gives the majority.
    assign cout  = ha0_c | ha1_c;

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial WIDTH-bit adder (subtract too when SERIAL_ADD_SUB_EN is defined), one bit per clock.
// Latency: start accepted at edge k -> done and sum_out/carry_out valid after edge k+WIDTH.
// Backpressure: start only sampled in IDLE; starts while busy/done are dropped, never queued.
module serial_add_seq
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
);

    localparam int CW = clog2(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_nxt;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             b_bit;
    logic             fa_sum;
    logic             fa_cout;
    logic             last;

`ifdef SERIAL_ADD_SUB_EN
    logic             sub_q;

    // Subtraction is a + ~b + 1: invert b on its way into the cell, carry seeded with 1.
    assign b_bit = b_sh[0] ^ sub_q;
`else
    logic             sub_q;

    assign sub_q = 1'b0;
    assign b_bit = b_sh[0];
`endif

    assign last    = (cnt == CW'(WIDTH - 1));
    assign res_nxt = {fa_sum, res_sh[WIDTH-1:1]};

    full_add_bit u_fa (
        .a    (a_sh[0]),
        .b    (b_bit),
        .cin  (carry),
        .s    (fa_sum),
        .cout (fa_cout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status outputs; DONE always lasts exactly one cycle.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, LSB-first shifting, carry flop and result publication.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            sum_out   <= '0;
            carry_out <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            sub_q     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh  <= a_in;
                        b_sh  <= b_in;
                        cnt   <= '0;
`ifdef SERIAL_ADD_SUB_EN
                        sub_q <= sub;
                        carry <= sub;
`else
                        carry <= 1'b0;
`endif
                    end
                end
                S_SHIFT: begin
                    a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                    res_sh <= res_nxt;
                    carry  <= fa_cout;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        sum_out   <= res_nxt;
                        carry_out <= fa_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The add-only build ties sub_q low; keep it referenced so it never floats unused.
    logic unused_sub;
    assign unused_sub = sub_q & 1'b0;

endmodule

// File: tb/tb_serial_add_seq.sv
module tb_serial_add_seq;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum_out;
    logic         carry_out;
`ifdef SERIAL_ADD_SUB_EN
    logic         sub;
    logic         sub_v = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    logic [W:0] exp_q[$];

    serial_add_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef SERIAL_ADD_SUB_EN
        .sub       (sub),
`endif
        .a_in      (a_in),
        .b_in      (b_in),
        .busy      (busy),
        .done      (done),
        .sum_out   (sum_out),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer add (or a + ~b + 1 for subtract) in WIDTH+1 bits.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SERIAL_ADD_SUB_EN
        if (sub_v) return {1'b0, a} + {1'b0, ~b} + 9'd1;
`endif
        return {1'b0, a} + {1'b0, b};
    endfunction

    // Drive a single-cycle start from IDLE and queue the expected result.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
        sub   = sub_v;
`endif
        exp_q.push_back(model(a, b));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done; reports cycles waited and busy samples seen.
    task automatic wait_done(input int budget, output bit got, output int cyc, output int bcnt);
        got  = 1'b0;
        cyc  = 0;
        bcnt = 0;
        while (cyc < budget) begin
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
`ifdef SERIAL_ADD_SUB_EN
        sub   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (sum_out !== 8'h00) begin errors++; $display("FAIL reset_sum: got %h expected 00", sum_out); end
        checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b expected 0", carry_out); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        bit got; int cyc; int bcnt; logic [W:0] exp;
        issue(8'h3C, 8'h0F);
        wait_done(40, got, cyc, bcnt);
        checks++;
        if (!got) begin
            errors++; $display("FAIL basic_timeout: no done within %0d cycles", cyc);
            exp_q.delete();
        end else begin
            exp = exp_q.pop_front();
            checks++; if ({carry_out, sum_out} !== exp) begin errors++; $display("FAIL basic_result: got %h expected %h", {carry_out, sum_out}, exp); end
            checks++; if (exp !== 9'h04B) begin errors++; $display("FAIL basic_model: got %h expected 04B", exp); end
            checks++; if (bcnt !== W) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected %0d", bcnt, W); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_in_done: got %b expected 0", busy); end
            @(negedge clk);
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b expected 0", done); end
            repeat (3) @(negedge clk);
            checks++; if ({carry_out, sum_out} !== 9'h04B) begin errors++; $display("FAIL basic_hold: got %h expected 04B", {carry_out, sum_out}); end
        end
    endtask

    task automatic test_carry;
        logic [W-1:0] av[2];
        logic [W-1:0] bv[2];
        logic [W:0]   ev[2];
        bit got; int cyc; int bcnt; logic [W:0] exp;
        av[0] = 8'hFF; bv[0] = 8'h01; ev[0] = 9'h100;
        av[1] = 8'hFF; bv[1] = 8'hFF; ev[1] = 9'h1FE;
        for (int i = 0; i < 2; i++) begin
            issue(av[i], bv[i]);
            wait_done(40, got, cyc, bcnt);
            checks++;
            if (!got) begin
                errors++; $display("FAIL carry_timeout[%0d]: no done within %0d cycles", i, cyc);
                exp_q.delete();
            end else begin
                exp = exp_q.pop_front();
                checks++; if ({carry_out, sum_out} !== exp) begin errors++; $display("FAIL carry_result[%0d]: got %h expected %h", i, {carry_out, sum_out}, exp); end
                checks++; if ({carry_out, sum_out} !== ev[i]) begin errors++; $display("FAIL carry_const[%0d]: got %h expected %h", i, {carry_out, sum_out}, ev[i]); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_start_held;
        bit got; int cyc; int bcnt; int gap; int extra; logic [W:0] exp;
        @(negedge clk);
        a_in = 8'h12; b_in = 8'h34; start = 1'b1;
        exp_q.push_back(model(8'h12, 8'h34));
        @(negedge clk);
        a_in = 8'h55; b_in = 8'h22;
        wait_done(40, got, cyc, bcnt);
        checks++;
        if (!got) begin
            errors++; $display("FAIL held_timeout: no done within %0d cycles", cyc);
            start = 1'b0; exp_q.delete();
            return;
        end
        exp = exp_q.pop_front();
        checks++; if ({carry_out, sum_out} !== exp) begin errors++; $display("FAIL held_first: got %h expected %h", {carry_out, sum_out}, exp); end
        exp_q.push_back(model(8'h55, 8'h22));
        @(negedge clk);
        wait_done(40, got, cyc, bcnt);
        gap = cyc + 1;
        start = 1'b0;
        checks++;
        if (!got) begin
            errors++; $display("FAIL held_second_timeout: no done within %0d cycles", cyc);
            exp_q.delete();
            return;
        end
        exp = exp_q.pop_front();
        checks++; if ({carry_out, sum_out} !== exp) begin errors++; $display("FAIL held_second: got %h expected %h", {carry_out, sum_out}, exp); end
        checks++; if (gap !== W + 2) begin errors++; $display("FAIL held_spacing: got %0d expected %0d", gap, W + 2); end
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL held_extra_done: got %0d expected 0", extra); end
    endtask

    task automatic test_reset_mid;
        bit got; int cyc; int bcnt; int seen; logic [W:0] exp;
        @(negedge clk);
        a_in = 8'h77; b_in = 8'h11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b expected 0", done); end
        checks++; if (sum_out !== 8'h00) begin errors++; $display("FAIL rstmid_sum: got %h expected 00", sum_out); end
        checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL rstmid_carry: got %b expected 0", carry_out); end
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d expected 0", seen); end
        issue(8'h01, 8'h01);
        wait_done(40, got, cyc, bcnt);
        checks++;
        if (!got) begin
            errors++; $display("FAIL rstmid_fresh_timeout: no done within %0d cycles", cyc);
            exp_q.delete();
        end else begin
            exp = exp_q.pop_front();
            checks++; if ({carry_out, sum_out} !== exp) begin errors++; $display("FAIL rstmid_fresh: got %h expected %h", {carry_out, sum_out}, exp); end
            checks++; if ({carry_out, sum_out} !== 9'h002) begin errors++; $display("FAIL rstmid_fresh_const: got %h expected 002", {carry_out, sum_out}); end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        bit pend; bit chk_busy; int last_done; int ndone;
        logic [W-1:0] a; logic [W-1:0] b; logic [W:0] exp;
        pend = 1'b1; chk_busy = 1'b0; last_done = -1; ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (chk_busy) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept[%0d]: busy got %b expected 1", i, busy); end
                chk_busy = 1'b0;
            end
            if (done === 1'b1) begin
                ndone++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_unexpected_done[%0d]: got %h expected none", i, {carry_out, sum_out});
                end else begin
                    exp = exp_q.pop_front();
                    if ({carry_out, sum_out} !== exp) begin errors++; $display("FAIL b2b_result[%0d]: got %h expected %h", i, {carry_out, sum_out}, exp); end
                end
                if (last_done >= 0) begin
                    checks++; if (i - last_done !== W + 2) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", i, i - last_done, W + 2); end
                end
                last_done = i;
            end
            a = W'($urandom_range(0, 255));
            b = W'($urandom_range(0, 255));
            a_in = a; b_in = b; start = 1'b1;
            if (pend) begin
                exp_q.push_back(model(a, b));
                pend = 1'b0;
                chk_busy = 1'b1;
            end
            if (done === 1'b1) pend = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        checks++; if (ndone !== 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", ndone); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_leftover: got %0d expected 0", exp_q.size()); end
        exp_q.delete();
        repeat (12) @(negedge clk);
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_sub;
        logic [W-1:0] av[2];
        logic [W-1:0] bv[2];
        logic [W:0]   ev[2];
        bit got; int cyc; int bcnt; logic [W:0] exp;
        av[0] = 8'h10; bv[0] = 8'h01; ev[0] = 9'h10F;
        av[1] = 8'h01; bv[1] = 8'h02; ev[1] = 9'h0FF;
        sub_v = 1'b1;
        for (int i = 0; i < 2; i++) begin
            issue(av[i], bv[i]);
            wait_done(40, got, cyc, bcnt);
            checks++;
            if (!got) begin
                errors++; $display("FAIL sub_timeout[%0d]: no done within %0d cycles", i, cyc);
                exp_q.delete();
            end else begin
                exp = exp_q.pop_front();
                checks++; if ({carry_out, sum_out} !== exp) begin errors++; $display("FAIL sub_result[%0d]: got %h expected %h", i, {carry_out, sum_out}, exp); end
                checks++; if ({carry_out, sum_out} !== ev[i]) begin errors++; $display("FAIL sub_const[%0d]: got %h expected %h", i, {carry_out, sum_out}, ev[i]); end
            end
            @(negedge clk);
        end
        sub_v = 1'b0;
        sub   = 1'b0;
    endtask
`endif

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        test_reset();
        test_basic();
        test_carry();
        test_start_held();
        test_reset_mid();
        test_back_to_back();
`ifdef SERIAL_ADD_SUB_EN
        test_sub();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
